fp_add_norm: RTL

- Pipelined back end of the FP16 adder in the FC datapath. It sits directly downstream of the mantissa right-shift alignment stage.
- It takes the larger operand and the aligned smaller mantissa, with its 2 appended guard/round bits. It then adds or subtracts, normalises, rounds to nearest-even and packs an IEEE half-precision result.
- Three register stages, valid/ready handshake.

---
 rtl/fp_add_norm.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fp_add_norm.sv
`default_nettype none
// fp_add_norm: FP16 adder back end -- add/sub, normalise, round-to-nearest-even, pack.
// Three register stages with a single global valid/ready enable. Rev 1.0
module fp_add_norm #(
  parameter int EXPWIDTH  = 5,
  parameter int MANTWIDTH = 11,
  parameter int BIAS      = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  output logic                          i_ready,
  input  logic                          sign_a,
  input  logic                          sign_b,
  input  logic [EXPWIDTH-1:0]           exp_big,
  input  logic [MANTWIDTH-1:0]          mant_big,
  input  logic [MANTWIDTH+1:0]          mant_small,
  output logic                          o_valid,
  input  logic                          o_ready,
  output logic [EXPWIDTH+MANTWIDTH-1:0] o_data
);
  localparam int W   = MANTWIDTH + 2;
  localparam int FW  = MANTWIDTH - 1;
  localparam int LZW = $clog2(W + 1);
  localparam logic [EXPWIDTH-1:0] EXP_MAX = EXPWIDTH'(2 * BIAS + 1);

  logic adv;
  assign adv     = o_ready | ~o_valid;
  assign i_ready = adv;

  logic [W:0] raw_sum, abs_sum;
  logic       eff_sub, sum_sign, in_inf;

  always_comb begin
    eff_sub = sign_a ^ sign_b;
    in_inf  = (exp_big == EXP_MAX);
    if (eff_sub) raw_sum = {1'b0, mant_big, 2'b00} - {1'b0, mant_small};
    else         raw_sum = {1'b0, mant_big, 2'b00} + {1'b0, mant_small};
    abs_sum  = raw_sum;
    sum_sign = sign_a;
    if (eff_sub && raw_sum[W]) begin
      abs_sum  = -raw_sum;
      sum_sign = ~sign_a;
    end
    // Infinity always carries the larger operand's sign.
    if (in_inf) sum_sign = sign_a;
  end

  logic                s1_valid, s1_sign, s1_zero, s1_inf;
  logic [EXPWIDTH-1:0] s1_exp;
  logic [W:0]          s1_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_inf   <= 1'b0;
      s1_exp   <= '0;
      s1_sum   <= '0;
    end else if (adv) begin
      s1_valid <= i_valid;
      s1_sign  <= sum_sign;
      s1_zero  <= (exp_big == '0);
      s1_inf   <= in_inf;
      s1_exp   <= exp_big;
      s1_sum   <= abs_sum;
    end
  end

  logic [LZW-1:0]      lz;
  logic                n_sign, n_zero, n_inf;
  logic [EXPWIDTH-1:0] n_exp;
  logic [W-1:0]        n_norm;

  always_comb begin
    lz = LZW'(W);
    for (int i = 0; i < W; i++) begin
      if (s1_sum[i]) lz = LZW'(W - 1 - i);
    end
  end

  always_comb begin
    n_sign = s1_sign;
    n_zero = s1_zero;
    n_inf  = s1_inf;
    n_exp  = s1_exp;
    n_norm = s1_sum[W-1:0];
    if (s1_sum == '0) begin
      // Exact cancellation yields +0.
      n_zero = 1'b1;
      if (!s1_inf) n_sign = 1'b0;
    end else if (s1_sum[W]) begin
      n_norm = {s1_sum[W:2], s1_sum[1] | s1_sum[0]};
      n_exp  = s1_exp + EXPWIDTH'(1);
    end else if (32'(lz) >= 32'(s1_exp)) begin
      n_zero = 1'b1;
    end else begin
      n_norm = s1_sum[W-1:0] << lz;
      n_exp  = s1_exp - EXPWIDTH'(lz);
    end
  end

  logic                s2_valid, s2_sign, s2_zero, s2_inf;
  logic [EXPWIDTH-1:0] s2_exp;
  logic [W-1:0]        s2_norm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_inf   <= 1'b0;
      s2_exp   <= '0;
      s2_norm  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_sign  <= n_sign;
      s2_zero  <= n_zero;
      s2_inf   <= n_inf;
      s2_exp   <= n_exp;
      s2_norm  <= n_norm;
    end
  end

  logic                          round_up, rnd_ovf;
  logic [FW-1:0]                 frac_r;
  logic [EXPWIDTH:0]             exp_r;
  logic [EXPWIDTH+MANTWIDTH-1:0] packed_res;

  always_comb begin
    round_up = s2_norm[1] & (s2_norm[0] | s2_norm[2]);
    rnd_ovf  = round_up & (&s2_norm[W-1:2]);
    frac_r   = s2_norm[W-2:2] + FW'(round_up);
    exp_r    = {1'b0, s2_exp} + (EXPWIDTH+1)'(rnd_ovf);
    if (s2_inf)                        packed_res = {s2_sign, EXP_MAX, {FW{1'b0}}};
    else if (s2_zero)                  packed_res = {s2_sign, {(EXPWIDTH+FW){1'b0}}};
    else if (exp_r >= {1'b0, EXP_MAX}) packed_res = {s2_sign, EXP_MAX, {FW{1'b0}}};
    else                               packed_res = {s2_sign, exp_r[EXPWIDTH-1:0], frac_r};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (adv) begin
      o_valid <= s2_valid;
      o_data  <= packed_res;
    end
  end
endmodule
`default_nettype wire
